// File: rtl/video_pkg.sv
// Shared encodings for the line render scheduler: FSM states, renderer indices, budget width.
package video_pkg;

  localparam int NUM_REQ  = 3;
  localparam int IDX_W    = 2;
  localparam int BUDGET_W = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef logic [IDX_W-1:0] req_idx_t;

  localparam req_idx_t REQ_L0  = 2'd0;
  localparam req_idx_t REQ_L1  = 2'd1;
  localparam req_idx_t REQ_SPR = 2'd2;

endpackage

// File: rtl/render_req_pick.sv
// Combinational pick of the lowest enabled renderer index at or above base.
// Zero latency; no handshake, vld=0 when nothing qualifies.
module render_req_pick
  import video_pkg::*;
(
  input  logic [NUM_REQ-1:0] en,
  input  req_idx_t           base,
  output req_idx_t           idx,
  output logic               vld
);

  // Scan high to low so the lowest qualifying index is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (en[i] && (i >= int'(base))) begin
        idx = req_idx_t'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_render_scheduler.sv
// Per-line renderer sequencer: start at LS+1, next start at done+1, line_done at last done+1.
// Renderers are never stalled; overruns (budget or late line) are aborted and flagged sticky.
module line_render_scheduler
  import video_pkg::*;
#(
  parameter int V_LINES     = 480,
  parameter int LINE_BUDGET = 1550
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               next_frame,
  input  logic               next_line,
  input  logic [8:0]         display_line_idx,
  input  logic [NUM_REQ-1:0] layer_en,
  input  logic [NUM_REQ-1:0] render_done,
  output logic [NUM_REQ-1:0] render_start,
  output logic               render_abort,
  output logic [8:0]         render_line,
  output logic               lb_wr_sel,
  output logic               line_done,
  output logic               overrun,
  input  logic               overrun_clr
);

  // Counter is 0 in the first cycle after LS, so this value is hit at LS+LINE_BUDGET-1.
  localparam logic [BUDGET_W-1:0] ABORT_CNT = BUDGET_W'(LINE_BUDGET - 2);
  localparam logic [8:0]          LAST_LINE = 9'(V_LINES - 1);

  logic [1:0]          state_q, state_d;
  req_idx_t            cur_q, cur_d;
  req_idx_t            pick_base, pick_idx;
  logic                pick_vld;
  logic [NUM_REQ-1:0]  en_q, pick_en;
  logic [BUDGET_W-1:0] cnt_q;
  logic                ls, busy, done_cur, budget_hit, line_done_d;

  assign ls         = next_line | next_frame;
  assign busy       = (state_q != ST_IDLE);
  assign done_cur   = (state_q == ST_WAIT) && render_done[cur_q];
  assign budget_hit = busy && (cnt_q == ABORT_CNT);

  // At LS the fresh enables are not yet latched, so pick from the live inputs.
  assign pick_en   = ls ? layer_en : en_q;
  assign pick_base = ls ? req_idx_t'(0) : cur_q + req_idx_t'(1);

  render_req_pick u_pick (
    .en   (pick_en),
    .base (pick_base),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    render_abort = 1'b0;
    line_done_d  = 1'b0;
    if (ls) begin
      render_abort = busy;
      if (pick_vld) begin
        state_d = ST_ISSUE;
        cur_d   = pick_idx;
      end else begin
        state_d     = ST_IDLE;
        line_done_d = 1'b1;
      end
    end else if (done_cur && !pick_vld) begin
      state_d     = ST_IDLE;
      line_done_d = 1'b1;
    end else if (budget_hit) begin
      state_d      = ST_IDLE;
      render_abort = 1'b1;
    end else if (done_cur) begin
      state_d = ST_ISSUE;
      cur_d   = pick_idx;
    end else if (state_q == ST_ISSUE) begin
      state_d = ST_WAIT;
    end
  end

  always_comb begin
    render_start = '0;
    if (state_q == ST_ISSUE) render_start[cur_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      en_q        <= '0;
      cnt_q       <= '0;
      render_line <= '0;
      lb_wr_sel   <= 1'b0;
      line_done   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      line_done <= line_done_d;
      if (ls) begin
        en_q      <= layer_en;
        lb_wr_sel <= ~lb_wr_sel;
        cnt_q     <= '0;
        if (next_frame || (display_line_idx == LAST_LINE)) render_line <= '0;
        else                                               render_line <= display_line_idx + 9'd1;
      end else if (busy && (cnt_q != '1)) begin
        cnt_q <= cnt_q + BUDGET_W'(1);
      end
      if (render_abort)     overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_render_scheduler.sv
// Directed bench for line_render_scheduler: sequencing, line wrap, budget abort, late line, async reset.
module tb_line_render_scheduler;

  logic       clk, rst_n, next_frame, next_line, overrun_clr;
  logic [8:0] display_line_idx;
  logic [2:0] layer_en, render_done;
  logic [2:0] render_start;
  logic       render_abort, lb_wr_sel, line_done, overrun;
  logic [8:0] render_line;

  int checks = 0;
  int failures = 0;
  int aborts = 0;
  logic exp_sel = 1'b0;

  line_render_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .next_frame       (next_frame),
    .next_line        (next_line),
    .display_line_idx (display_line_idx),
    .layer_en         (layer_en),
    .render_done      (render_done),
    .render_start     (render_start),
    .render_abort     (render_abort),
    .render_line      (render_line),
    .lb_wr_sel        (lb_wr_sel),
    .line_done        (line_done),
    .overrun          (overrun),
    .overrun_clr      (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (render_abort === 1'b1) aborts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ls(input logic nf, input logic nl);
    next_frame = nf;
    next_line  = nl;
    tick();
    next_frame = 1'b0;
    next_line  = 1'b0;
    exp_sel    = ~exp_sel;
  endtask

  task automatic pulse_done(input logic [2:0] m);
    render_done = m;
    tick();
    render_done = 3'b000;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({render_start, render_abort, render_line, lb_wr_sel, line_done, overrun} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {render_start, render_abort, render_line, lb_wr_sel, line_done, overrun});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_line();
    int a0;
    logic [2:0] m;
    a0 = aborts;
    layer_en = 3'b111;
    display_line_idx = 9'd41;
    pulse_ls(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (render_start !== 3'b001) begin failures++; $display("FAIL full_start0 got=%b exp=001", render_start); end
    checks++;
    if (render_line !== 9'd42) begin failures++; $display("FAIL full_line got=%0d exp=42", render_line); end
    checks++;
    if (lb_wr_sel !== exp_sel) begin failures++; $display("FAIL full_sel got=%b exp=%b", lb_wr_sel, exp_sel); end
    for (int s = 0; s < 3; s++) begin
      repeat (100) tick();
      m = 3'(1 << s);
      pulse_done(m);
      @(negedge clk);
      checks++;
      if (s < 2) begin
        if (render_start !== 3'(1 << (s + 1)) || line_done !== 1'b0) begin
          failures++;
          $display("FAIL full_next_start s=%0d got start=%b done=%b", s, render_start, line_done);
        end
      end else if (line_done !== 1'b1 || render_start !== 3'b000) begin
        failures++;
        $display("FAIL full_line_done got done=%b start=%b exp done=1 start=000", line_done, render_start);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (line_done !== 1'b0 || overrun !== 1'b0 || aborts != a0) begin
      failures++;
      $display("FAIL full_clean got done=%b ovr=%b aborts=%0d exp 0 0 %0d", line_done, overrun, aborts, a0);
    end
  endtask

  task automatic test_line_wrap();
    layer_en = 3'b000;
    display_line_idx = 9'd479;
    pulse_ls(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (render_line !== 9'd0 || lb_wr_sel !== exp_sel) begin
      failures++;
      $display("FAIL wrap_479 got line=%0d sel=%b exp 0 %b", render_line, lb_wr_sel, exp_sel);
    end
    checks++;
    if (line_done !== 1'b1 || render_start !== 3'b000) begin
      failures++;
      $display("FAIL empty_line got done=%b start=%b exp 1 000", line_done, render_start);
    end
    display_line_idx = 9'd200;
    pulse_ls(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (render_line !== 9'd201 || lb_wr_sel !== exp_sel) begin
      failures++;
      $display("FAIL line_200 got line=%0d sel=%b exp 201 %b", render_line, lb_wr_sel, exp_sel);
    end
    pulse_ls(1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (render_line !== 9'd0) begin failures++; $display("FAIL frame_and_line got=%0d exp=0", render_line); end
    display_line_idx = 9'd77;
    pulse_ls(1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (render_line !== 9'd0 || lb_wr_sel !== exp_sel) begin
      failures++;
      $display("FAIL frame_only got line=%0d sel=%b exp 0 %b", render_line, lb_wr_sel, exp_sel);
    end
  endtask

  task automatic test_sparse();
    layer_en = 3'b101;
    display_line_idx = 9'd10;
    pulse_ls(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (render_start !== 3'b001) begin failures++; $display("FAIL sparse_start0 got=%b exp=001", render_start); end
    tick();
    pulse_done(3'b010);
    @(negedge clk);
    checks++;
    if (render_start !== 3'b000 || line_done !== 1'b0) begin
      failures++;
      $display("FAIL sparse_ignore got start=%b done=%b exp 000 0", render_start, line_done);
    end
    pulse_done(3'b001);
    @(negedge clk);
    checks++;
    if (render_start !== 3'b100) begin failures++; $display("FAIL sparse_start2 got=%b exp=100", render_start); end
    tick();
    pulse_done(3'b100);
    @(negedge clk);
    checks++;
    if (line_done !== 1'b1) begin failures++; $display("FAIL sparse_done got=%b exp=1", line_done); end
  endtask

  task automatic test_budget();
    int first, lds;
    first = 0;
    lds = 0;
    layer_en = 3'b100;
    pulse_ls(1'b0, 1'b1);
    for (int k = 1; k <= 1560; k++) begin
      @(negedge clk);
      if (render_abort === 1'b1 && first == 0) first = k;
      if (line_done === 1'b1) lds++;
      tick();
    end
    checks++;
    if (first != 1549) begin failures++; $display("FAIL budget_abort_cycle got=T+%0d exp=T+1549", first); end
    checks++;
    if (overrun !== 1'b1 || lds != 0) begin
      failures++;
      $display("FAIL budget_overrun got ovr=%b line_dones=%0d exp 1 0", overrun, lds);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clr got=%b exp=0", overrun); end
    layer_en = 3'b001;
    pulse_ls(1'b0, 1'b1);
    tick();
    next_line = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (render_abort !== 1'b1) begin failures++; $display("FAIL clr_race_abort got=%b exp=1", render_abort); end
    tick();
    next_line = 1'b0;
    overrun_clr = 1'b0;
    exp_sel = ~exp_sel;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1 || render_start !== 3'b001) begin
      failures++;
      $display("FAIL clr_race_set got ovr=%b start=%b exp 1 001", overrun, render_start);
    end
    tick();
    pulse_done(3'b001);
    @(negedge clk);
    checks++;
    if (line_done !== 1'b1) begin failures++; $display("FAIL clr_race_finish got=%b exp=1", line_done); end
  endtask

  task automatic test_late_line();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    layer_en = 3'b011;
    pulse_ls(1'b0, 1'b1);
    tick();
    pulse_done(3'b001);
    @(negedge clk);
    checks++;
    if (render_start !== 3'b010) begin failures++; $display("FAIL late_start1 got=%b exp=010", render_start); end
    tick();
    tick();
    next_line = 1'b1;
    @(negedge clk);
    checks++;
    if (render_abort !== 1'b1 || render_start !== 3'b000) begin
      failures++;
      $display("FAIL late_abort got abort=%b start=%b exp 1 000", render_abort, render_start);
    end
    tick();
    next_line = 1'b0;
    exp_sel = ~exp_sel;
    @(negedge clk);
    checks++;
    if (render_start !== 3'b001 || overrun !== 1'b1 || render_abort !== 1'b0) begin
      failures++;
      $display("FAIL late_restart got start=%b ovr=%b abort=%b exp 001 1 0", render_start, overrun, render_abort);
    end
    tick();
    pulse_done(3'b001);
    tick();
    pulse_done(3'b010);
    @(negedge clk);
    checks++;
    if (line_done !== 1'b1) begin failures++; $display("FAIL late_finish got=%b exp=1", line_done); end
  endtask

  task automatic test_async_reset();
    int a0;
    layer_en = 3'b001;
    display_line_idx = 9'd99;
    pulse_ls(1'b0, 1'b1);
    tick();
    a0 = aborts;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({render_start, render_abort, render_line, lb_wr_sel, line_done, overrun} !== 15'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {render_start, render_abort, render_line, lb_wr_sel, line_done, overrun});
    end
    tick();
    rst_n = 1'b1;
    exp_sel = 1'b0;
    tick();
    checks++;
    if (aborts != a0) begin failures++; $display("FAIL reset_no_abort got=%0d exp=%0d", aborts, a0); end
    pulse_ls(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (lb_wr_sel !== 1'b1 || render_start !== 3'b001) begin
      failures++;
      $display("FAIL post_reset got sel=%b start=%b exp 1 001", lb_wr_sel, render_start);
    end
    tick();
    pulse_done(3'b001);
  endtask

  initial begin
    rst_n = 1'b0;
    next_frame = 1'b0;
    next_line = 1'b0;
    overrun_clr = 1'b0;
    display_line_idx = 9'd0;
    layer_en = 3'b000;
    render_done = 3'b000;
    test_reset();
    test_full_line();
    test_line_wrap();
    test_sparse();
    test_budget();
    test_late_line();
    test_async_reset();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
